banked_data_mem: RTL

- Parametrised successor to the single-cycle MIPS memory.
- Three independently sized regions (text, data, stack) at parametrised byte base addresses.
- Per-byte write enables; configurable multi-cycle access latency with a request/stall handshake into the MEM pipeline stage.
- Registered fault reporting for unmapped or misaligned accesses.
- Sits between the EX/MEM and MEM/WB pipeline registers; hazard unit consumes Stall.

---
 rtl/banked_data_mem.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/banked_data_mem.sv
// Banked text/data/stack memory with a multi-cycle request/stall handshake and registered faults.
// Define MEM_TRACE_EN to print one trace line per completed access.
module banked_data_mem #(
  parameter logic [31:0] TEXT_BASE   = 32'h0000_0000,
  parameter int          TEXT_WORDS  = 256,
  parameter logic [31:0] DATA_BASE   = 32'h0000_0400,
  parameter int          DATA_WORDS  = 256,
  parameter logic [31:0] STACK_TOP   = 32'h7FFF_FFFC,
  parameter int          STACK_WORDS = 256,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] UNDEF_VAL   = 32'hDEAD_BEEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Req,
  input  logic        WE,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic [3:0]  BE,
  output logic [31:0] RD,
  output logic        Done,
  output logic        Stall,
  output logic        Fault,
  output logic [31:0] FaultAddr
);

  localparam int TIDX_W = (TEXT_WORDS  > 1) ? $clog2(TEXT_WORDS)  : 1;
  localparam int DIDX_W = (DATA_WORDS  > 1) ? $clog2(DATA_WORDS)  : 1;
  localparam int SIDX_W = (STACK_WORDS > 1) ? $clog2(STACK_WORDS) : 1;

  localparam logic [32:0] TEXT_LO  = {1'b0, TEXT_BASE};
  localparam logic [32:0] TEXT_HI  = TEXT_LO + 33'(4 * TEXT_WORDS);
  localparam logic [32:0] DATA_LO  = {1'b0, DATA_BASE};
  localparam logic [32:0] DATA_HI  = DATA_LO + 33'(4 * DATA_WORDS);
  localparam logic [32:0] STACK_HI = {1'b0, STACK_TOP};
  localparam logic [32:0] STACK_LO = STACK_HI - 33'(4 * (STACK_WORDS - 1));

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      r_state, w_nextState;
  logic [3:0]  r_count, w_nextCount;
  logic        w_accept, w_complete;

  logic [31:0] r_a, r_wd;
  logic [3:0]  r_be;
  logic        r_we;

  logic [31:0] w_a, w_wd;
  logic [3:0]  w_be;
  logic        w_we;
  logic [32:0] w_a33;

  logic        w_hitText, w_hitData, w_hitStack, w_hitAny, w_misal, w_fault;
  logic        w_wrText, w_wrData, w_wrStack;
  logic [TIDX_W-1:0] w_textIdx;
  logic [DIDX_W-1:0] w_dataIdx;
  logic [SIDX_W-1:0] w_stackIdx;
  logic [31:0] w_rdata;

  logic [31:0] r_textMem  [TEXT_WORDS];
  logic [31:0] r_dataMem  [DATA_WORDS];
  logic [31:0] r_stackMem [STACK_WORDS];

  logic [31:0] r_rd, r_faultAddr;
  logic        r_done, r_fault;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Req) begin
          w_accept    = 1'b1;
          w_nextCount = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            w_complete = 1'b1;
          end else begin
            w_nextState = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (r_count == 4'd1) begin
          w_complete  = 1'b1;
          w_nextCount = '0;
          w_nextState = S_IDLE;
        end else begin
          w_nextCount = r_count - 4'd1;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_a  <= A;
      r_wd <= WD;
      r_be <= BE;
      r_we <= WE;
    end
  end

  // A single-cycle access completes on its accept edge, so it decodes the live inputs.
  always_comb begin
    w_a  = (r_state == S_IDLE) ? A  : r_a;
    w_wd = (r_state == S_IDLE) ? WD : r_wd;
    w_be = (r_state == S_IDLE) ? BE : r_be;
    w_we = (r_state == S_IDLE) ? WE : r_we;
  end

  always_comb begin
    w_a33      = {1'b0, w_a};
    w_hitText  = (w_a33 >= TEXT_LO)  && (w_a33 <  TEXT_HI);
    w_hitData  = (w_a33 >= DATA_LO)  && (w_a33 <  DATA_HI);
    w_hitStack = (w_a33 >= STACK_LO) && (w_a33 <= STACK_HI);
    w_hitAny   = w_hitText || w_hitData || w_hitStack;
    w_misal    = (w_a[1:0] != 2'b00);
    w_fault    = w_misal || !w_hitAny || (w_we && (w_be == 4'b0000));
    w_textIdx  = TIDX_W'((w_a - TEXT_BASE) >> 2);
    w_dataIdx  = DIDX_W'((w_a - DATA_BASE) >> 2);
    w_stackIdx = SIDX_W'((STACK_TOP - w_a) >> 2);
    if (w_hitStack) begin
      w_rdata = r_stackMem[w_stackIdx];
    end else if (w_hitData) begin
      w_rdata = r_dataMem[w_dataIdx];
    end else begin
      w_rdata = r_textMem[w_textIdx];
    end
  end

  // Overlapping regions resolve stack over data over text; only the winner is written.
  always_comb begin
    w_wrStack = w_complete && w_we && !w_fault && w_hitStack;
    w_wrData  = w_complete && w_we && !w_fault && w_hitData && !w_hitStack;
    w_wrText  = w_complete && w_we && !w_fault && w_hitText && !w_hitData && !w_hitStack;
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (!RST && w_wrText && w_be[i])  r_textMem[w_textIdx][8*i +: 8]   <= w_wd[8*i +: 8];
      if (!RST && w_wrData && w_be[i])  r_dataMem[w_dataIdx][8*i +: 8]   <= w_wd[8*i +: 8];
      if (!RST && w_wrStack && w_be[i]) r_stackMem[w_stackIdx][8*i +: 8] <= w_wd[8*i +: 8];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd        <= '0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
      r_faultAddr <= '0;
    end else begin
      r_done  <= w_complete;
      r_fault <= w_complete && w_fault;
      if (w_complete && w_fault) r_faultAddr <= w_a;
      if (w_complete && !w_we)   r_rd <= w_fault ? UNDEF_VAL : w_rdata;
    end
  end

`ifdef MEM_TRACE_EN
  // An empty byte-enable write selects no aligned lane, so it is reported as misaligned.
  always_ff @(posedge CLK) begin
    if (!RST && w_complete) begin
      $display("%0t %s A=%h D=%h BE=%b fault=%0d", $time, w_we ? "W" : "R", w_a,
               w_we ? w_wd : (w_fault ? UNDEF_VAL : w_rdata), w_be, w_fault);
      if (w_fault) $display("%0t %s", $time, (w_hitAny && !w_misal && !w_we) ? "unallocated" :
                            (w_hitAny || w_misal) ? "misaligned" : "unallocated");
    end
  end
`else
`endif

  assign RD        = r_rd;
  assign Done      = r_done;
  assign Stall     = (r_state == S_BUSY);
  assign Fault     = r_fault;
  assign FaultAddr = r_faultAddr;

endmodule
